// File: rtl/mean_pkg.sv
// Shared constants and types for the sliding mean window.
// Contents: default sample width, tap count, fill/stride counter widths,
// and the window-fill FSM state type.
package mean_pkg;

  localparam int unsigned WID_DEF  = 16;
  localparam int unsigned N_TAPS   = 8;
  localparam int unsigned FILL_W   = 4;  // holds 0..N_TAPS
  localparam int unsigned STRIDE_W = 3;  // counts 0..STRIDE-1, STRIDE <= 8

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_e;

endpackage

// File: rtl/mean_tap_sreg.sv
// Tap shift register: on shift_en the new sample enters tap 0 and every
// tap moves one place older; the oldest tap falls off the end.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears all taps
//   shift_en shift one sample in this edge
//   din      incoming sample
//   taps     tap values, taps[0] newest
module mean_tap_sreg #(
  parameter int unsigned WID    = 16,
  parameter int unsigned N_TAPS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_en,
  input  logic [WID-1:0]               din,
  output logic [N_TAPS-1:0][WID-1:0]   taps
);

  logic [N_TAPS-1:0][WID-1:0] taps_q;

  // Shift toward higher indices; index 0 takes the new sample
  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q <= '0;
    end else if (shift_en) begin
      taps_q <= {taps_q[N_TAPS-2:0], din};
    end
  end

  assign taps = taps_q;

endmodule

// File: rtl/mean_window.sv
// Sliding window of the last N_TAPS accepted samples, feeding an averager.
// Signals a complete window once full, then every STRIDE-th accept.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   s_data/s_valid        upstream sample and its valid
//   s_ready               combinational, low only while flush is high
//   flush                 restart filling (taps keep their values)
//   out_000..out_007      window taps, out_000 newest
//   out_valid             registered one-cycle pulse per emitted window
//   fill_cnt              number of valid taps, 0..8
// Build option: define MEAN_WINDOW_HOLD_EN to drive the taps outputs from a
// snapshot taken on each emission instead of the live shift register.
module mean_window
  import mean_pkg::*;
#(
  parameter int unsigned WID    = WID_DEF,
  parameter int unsigned STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WID-1:0]    s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              flush,
  output logic [WID-1:0]    out_000,
  output logic [WID-1:0]    out_001,
  output logic [WID-1:0]    out_002,
  output logic [WID-1:0]    out_003,
  output logic [WID-1:0]    out_004,
  output logic [WID-1:0]    out_005,
  output logic [WID-1:0]    out_006,
  output logic [WID-1:0]    out_007,
  output logic              out_valid,
  output logic [FILL_W-1:0] fill_cnt
);

  state_e                     state_q, state_d;
  logic [FILL_W-1:0]          fill_q, fill_d;
  logic [STRIDE_W-1:0]        stride_q, stride_d;
  logic                       out_valid_q, out_valid_d;
  logic                       accept;
  logic [N_TAPS-1:0][WID-1:0] taps;
  logic [N_TAPS-1:0][WID-1:0] win;

  assign s_ready = ~flush;
  assign accept  = s_valid & s_ready;

  mean_tap_sreg #(
    .WID    (WID),
    .N_TAPS (N_TAPS)
  ) u_sreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .din      (s_data),
    .taps     (taps)
  );

  // Fill tracking and emission decision
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    stride_d    = stride_q;
    out_valid_d = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      fill_d   = '0;
      stride_d = '0;
    end else if (accept) begin
      case (state_q)
        EMPTY: begin
          state_d = FILLING;
          fill_d  = FILL_W'(1);
        end
        FILLING: begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(N_TAPS - 1)) begin
            state_d     = FULL;
            out_valid_d = 1'b1;
            stride_d    = '0;
          end
        end
        FULL: begin
          // Counter holds accepts since last emission, minus one
          if (stride_q == STRIDE_W'(STRIDE - 1)) begin
            out_valid_d = 1'b1;
            stride_d    = '0;
          end else begin
            stride_d = stride_q + STRIDE_W'(1);
          end
        end
        default: begin
          state_d = EMPTY;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      fill_q      <= '0;
      stride_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      stride_q    <= stride_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MEAN_WINDOW_HOLD_EN
  logic [N_TAPS-1:0][WID-1:0] snap_q;
  logic [N_TAPS-1:0][WID-1:0] taps_nxt;

  // Snapshot the window as it will look after this edge's shift
  assign taps_nxt = {taps[N_TAPS-2:0], s_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else if (out_valid_d) begin
      snap_q <= taps_nxt;
    end
  end

  assign win = snap_q;
`else
  assign win = taps;
`endif

  assign out_000   = win[0];
  assign out_001   = win[1];
  assign out_002   = win[2];
  assign out_003   = win[3];
  assign out_004   = win[4];
  assign out_005   = win[5];
  assign out_006   = win[6];
  assign out_007   = win[7];
  assign out_valid = out_valid_q;
  assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_mean_window.sv
// Bench for mean_window: two instances (STRIDE=1 and STRIDE=4) share one
// stimulus stream; a history-based model predicts windows and emissions.
module tb_mean_window;

  localparam int WID = 16;
  typedef logic [7:0][WID-1:0] win_t;

  logic           clk = 1'b0;
  logic           rst, flush, s_valid;
  logic [WID-1:0] s_data;

  logic           rdy_a, rdy_b, val_a, val_b;
  logic [3:0]     fill_a, fill_b;
  win_t           tap_a, tap_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: last 8 accepted samples since reset (zero-padded), accepts
  // since the last reset/flush, last emitted windows, pending emissions.
  logic [WID-1:0] hist[$];
  int             n_acc;
  win_t           snap_a, snap_b;
  win_t           exp_a[$];
  win_t           exp_b[$];

  always #5 clk = ~clk;

  mean_window #(.WID(WID), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_a),
    .flush(flush),
    .out_000(tap_a[0]), .out_001(tap_a[1]), .out_002(tap_a[2]), .out_003(tap_a[3]),
    .out_004(tap_a[4]), .out_005(tap_a[5]), .out_006(tap_a[6]), .out_007(tap_a[7]),
    .out_valid(val_a), .fill_cnt(fill_a)
  );

  mean_window #(.WID(WID), .STRIDE(4)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_b),
    .flush(flush),
    .out_000(tap_b[0]), .out_001(tap_b[1]), .out_002(tap_b[2]), .out_003(tap_b[3]),
    .out_004(tap_b[4]), .out_005(tap_b[5]), .out_006(tap_b[6]), .out_007(tap_b[7]),
    .out_valid(val_b), .fill_cnt(fill_b)
  );

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic win_t cur_win();
    win_t w;
    for (int i = 0; i < 8; i++) w[i] = hist[i];
    return w;
  endfunction

  // Emission after the 8th accept, then every stride-th accept after that
  function automatic bit emits(input int n, input int stride);
    return (n == 8) || (n > 8 && ((n - 8) % stride) == 0);
  endfunction

  task automatic step(input bit r, input bit f, input bit v, input logic [WID-1:0] d);
    rst = r; flush = f; s_valid = v; s_data = d;
    #1;
    check("s_ready_a", 128'(rdy_a), 128'(!f));
    check("s_ready_b", 128'(rdy_b), 128'(!f));
    @(posedge clk);
    if (r) begin
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back('0);
      n_acc  = 0;
      snap_a = '0;
      snap_b = '0;
      exp_a.delete();
      exp_b.delete();
    end else if (f) begin
      n_acc = 0;
    end else if (v) begin
      hist.push_front(d);
      void'(hist.pop_back());
      n_acc++;
      if (emits(n_acc, 1)) begin snap_a = cur_win(); exp_a.push_back(snap_a); end
      if (emits(n_acc, 4)) begin snap_b = cur_win(); exp_b.push_back(snap_b); end
    end
    @(negedge clk);
    check("fill_cnt_a", 128'(fill_a), 128'((n_acc > 8) ? 8 : n_acc));
    check("fill_cnt_b", 128'(fill_b), 128'((n_acc > 8) ? 8 : n_acc));
`ifdef MEAN_WINDOW_HOLD_EN
    check("taps_a", 128'(tap_a), 128'(snap_a));
    check("taps_b", 128'(tap_b), 128'(snap_b));
`else
    check("taps_a", 128'(tap_a), 128'(cur_win()));
    check("taps_b", 128'(tap_b), 128'(cur_win()));
`endif
  endtask

  // Monitor: every out_valid pulse must match a pending emission and vice versa
  always @(negedge clk) begin
    win_t w;
    if (val_a === 1'b1 || exp_a.size() > 0) begin
      n_chk++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $display("FAIL out_valid_a: got unexpected pulse, want none at %0t", $time);
      end else begin
        w = exp_a.pop_front();
        if (val_a !== 1'b1) begin
          n_fail++;
          $display("FAIL out_valid_a: got %b want 1 at %0t", val_a, $time);
        end else if (tap_a !== w) begin
          n_fail++;
          $display("FAIL window_a: got %0h want %0h at %0t", tap_a, w, $time);
        end
      end
    end
    if (val_b === 1'b1 || exp_b.size() > 0) begin
      n_chk++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $display("FAIL out_valid_b: got unexpected pulse, want none at %0t", $time);
      end else begin
        w = exp_b.pop_front();
        if (val_b !== 1'b1) begin
          n_fail++;
          $display("FAIL out_valid_b: got %b want 1 at %0t", val_b, $time);
        end else if (tap_b !== w) begin
          n_fail++;
          $display("FAIL window_b: got %0h want %0h at %0t", tap_b, w, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0;
    @(negedge clk);

    // Reset, then fill with 10..17 and keep streaming 18..27
    step(1, 0, 0, 16'h0);
    step(1, 0, 1, 16'hdead);
    for (int k = 10; k <= 27; k++) step(0, 0, 1, 16'(k));
    // Idle cycles must not move anything
    for (int k = 0; k < 3; k++) step(0, 0, 0, 16'h5555);

    // Reset, 20 accepts for the stride-4 emission pattern
    step(1, 0, 0, 16'h0);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 16'(100 + k));

    // Flush with s_valid high after 5 accepts, then a full refill
    step(1, 0, 0, 16'h0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 16'(200 + k));
    step(0, 1, 1, 16'hbeef);
    for (int k = 0; k < 9; k++) step(0, 0, 1, 16'(300 + k));

    // Reset mid-FULL with s_valid held, then a fresh fill
    step(1, 0, 1, 16'hcafe);
    for (int k = 0; k < 9; k++) step(0, 0, 1, 16'(400 + k));

    // Random traffic with occasional flush and reset
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) < 7), 16'($urandom));
    end

    @(negedge clk);
    check("pending_a", 128'(exp_a.size()), 128'(0));
    check("pending_b", 128'(exp_b.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mean_window.md
MEAN_WINDOW -- requirements
Module: mean_window

Interface
REQ-001 The block SHALL have parameter WID, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter STRIDE, default 1, legal 1..8, meaning accepted samples between successive window emissions once full.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 s_data  input  WID  upstream sample.
REQ-006 s_valid  input  1  s_data is valid this cycle.
REQ-007 s_ready  output  1  the block can accept a sample this cycle.
REQ-008 flush  input  1  discard the window contents and restart filling.
REQ-009 out_000 .. out_007  output  WID each  window taps feeding mean_avg in_000..in_007; out_000 is the newest sample.
REQ-010 out_valid  output  1  one-cycle pulse: the taps hold a complete window to be averaged.
REQ-011 fill_cnt  output  4  number of valid taps, 0..8.

Function
REQ-012 A sample SHALL be accepted on an edge where s_valid and s_ready are both 1; no other edge shall alter the taps.
REQ-013 On accept: tap0 <= s_data, and tap i <= tap i-1 for i = 1..7; tap7 is discarded.
REQ-014 s_ready SHALL equal not flush (combinational); the block never back-pressures otherwise.
REQ-015 FSM states: EMPTY (fill_cnt=0), FILLING (1..7), FULL (8).
REQ-016 Transitions: EMPTY->FILLING on accept; FILLING->FULL on the accept that makes fill_cnt 8; any state->EMPTY on flush.
REQ-017 fill_cnt SHALL increment by 1 per accept and saturate at 8.
REQ-018 out_valid SHALL be registered and assert for exactly one cycle after the accept edge that takes fill_cnt from 7 to 8.
REQ-019 In FULL, a 3-bit stride counter SHALL count accepts; out_valid pulses after every STRIDE-th accept since the last emission, then the counter returns to 0.
REQ-020 With STRIDE=1, out_valid SHALL pulse after every accept while FULL.
REQ-021 When flush is asserted, s_ready=0, the accept is suppressed, fill_cnt and the stride counter clear next edge, and out_valid is 0 next cycle; the taps keep their values.
REQ-022 Tap data SHALL pass through unmodified: no arithmetic and no width change.

Reset
REQ-023 While rst=1 at a rising edge: all taps=0, fill_cnt=0, stride counter=0, out_valid=0, state=EMPTY.
REQ-024 rst SHALL override flush and s_valid; a sample presented during reset is dropped.
REQ-025 A reset during FILLING or FULL SHALL restart filling from EMPTY; the first out_valid then requires 8 new accepts.

Configuration
REQ-026 Macro MEAN_WINDOW_HOLD_EN: when defined, out_000..out_007 SHALL come from a snapshot register loaded only on the edge that raises out_valid, stable until the next emission; reset value 0.
REQ-027 Without MEAN_WINDOW_HOLD_EN, out_000..out_007 SHALL be the live taps, changing on every accept.

Structure
REQ-028 Package mean_pkg SHALL hold the WID default, N_TAPS=8, the FSM state typedef (EMPTY, FILLING, FULL) and the fill_cnt width constant.
REQ-029 The shift register SHALL be a sub-module mean_tap_sreg (parameters WID, N_TAPS; ports clk, rst, shift_en, din, taps); the FSM, counters and snapshot logic stay in mean_window.

Verification
REQ-030 Reset, then accept 10..17 on consecutive cycles -> out_valid pulses once, after the 17 accept; out_000=17 .. out_007=10; fill_cnt=8.
REQ-031 STRIDE=1, continue accepting 18..27 -> out_valid every cycle; the mean_avg downstream computes 14.5 then steps +1 per sample.
REQ-032 STRIDE=4, accept 20 samples -> out_valid pulses after samples 8, 12, 16 and 20 only.
REQ-033 Flush asserted with s_valid=1 after 5 accepts -> s_ready=0, sample dropped, fill_cnt=0 next cycle; 8 further accepts are needed before out_valid.
REQ-034 rst pulsed mid-FULL with s_valid held at 1 -> taps=0, fill_cnt=0, out_valid=0; a fresh 8-sample fill produces out_valid.
REQ-035 With MEAN_WINDOW_HOLD_EN defined, STRIDE=4 -> outputs stay constant between pulses; without the macro, out_000 tracks every accepted sample.
